pulpino_boot_ctrl: RTL and testbench
====================================

Name: pulpino_boot_ctrl

Overview:
Boot and run sequencer for the PULPino soft core inside the Qsys system. Drives the core's reset, fetch-enable, boot address and clock-gating config inputs in a fixed order. Honours the JTAG master-reset request and, optionally, a heartbeat watchdog on the 10-bit PIO export that restarts a hung core. Sits in the top level between the board keys/switches and the `sys` instance.

Parameters:
BOOT_ADDR0, 32'h0000_0000, boot address for boot_sel_i=0
BOOT_ADDR1, 32'h0000_8000, boot address for boot_sel_i=1
BOOT_ADDR2, 32'h1A00_0000, boot address for boot_sel_i=2
BOOT_ADDR3, 32'h0008_0000, boot address for boot_sel_i=3
RST_CYCLES, 16, cycles core reset is held low per boot (>=1)
SETTLE_CYCLES, 8, cycles between reset release and fetch enable (>=1)
WDT_CYCLES, 50_000_000, heartbeat timeout in cycles (>=2)

Ports:
clk_clk  in  1  system clock, same clock as the Qsys system
reset_reset_n  in  1  asynchronous active-low reset
master_reset_i  in  1  JTAG master reset request, synchronous to clk_clk, active high
start_i  in  1  run request level (key/switch, already synchronised)
boot_sel_i  in  2  boot address select
pio_i  in  10  PIO export, used as heartbeat
core_rst_n_o  out  1  reset to PULPino core, active low
fetch_enable_o  out  1  to pulpino config fetch_enable_i
boot_addr_o  out  32  to pulpino config boot_addr_i
clock_gating_o  out  1  to pulpino config clock_gating_i
testmode_o  out  1  to pulpino config testmode_i, constant 0
state_o  out  3  current FSM state
restart_cnt_o  out  8  watchdog restart count, saturating

Behaviour:
- Async reset: state IDLE, core_rst_n_o=0, fetch_enable_o=0, boot_addr_o=BOOT_ADDR0, clock_gating_o=1, testmode_o=0, restart_cnt_o=0, counters=0.
- State encoding: IDLE=0, HOLD=1, RESET=2, SETTLE=3, RUN=4.
- All outputs registered from next-state, so they change in the same cycle as state_o.
- IDLE: core_rst_n_o=0, fetch=0, gating=1. start_i=1 -> RESET.
- RESET: core_rst_n_o=0, fetch=0, gating=0.
  - boot_addr_o is latched from boot_sel_i on entry to RESET.
  - Stays exactly RST_CYCLES cycles, then -> SETTLE.
- SETTLE: core_rst_n_o=1, fetch=0. Stays exactly SETTLE_CYCLES cycles, then -> RUN.
- RUN: core_rst_n_o=1, fetch=1, gating=0.
  - fetch_enable_o rises RST_CYCLES+SETTLE_CYCLES cycles after the cycle state_o first reads RESET.
- HOLD: same outputs as IDLE. Left when master_reset_i=0: -> RESET if start_i=1, else -> IDLE.
- Transition priority, highest first:
  1. master_reset_i=1 in any state -> HOLD.
  2. start_i=0 in RESET/SETTLE/RUN -> IDLE (abort).
  3. Watchdog expiry (RUN only) -> RESET.
  4. Counter completion.
- boot_sel_i changes outside RESET entry are ignored; boot_addr_o stays stable through SETTLE and RUN.
- Phase counter clears on every state change. No wrap: the count compares against PARAM-1.
- testmode_o is always 0.

Optional Feature:
Macro PULPINO_BOOT_WDT_EN.
- Defined:
  - Register pio_q samples pio_i every cycle.
  - In RUN, the watchdog counter clears whenever pio_i != pio_q; otherwise it increments.
  - At WDT_CYCLES-1 the FSM goes to RESET (new boot_addr latched) and restart_cnt_o increments, saturating at 255.
  - The watchdog counter is cleared in every state except RUN.
- Undefined: no watchdog logic, pio_i unused, restart_cnt_o tied 0, RUN exits only via priorities 1 and 2.

Test Plan:
- Boot sequence: RST=16, SETTLE=8, boot_sel=2, raise start_i.
  -> state 0->2->3->4; core_rst_n_o rises after 16 cycles in RESET; fetch_enable_o rises 24 cycles after RESET entry; boot_addr_o=32'h1A00_0000.
- Master reset mid-RUN: pulse master_reset_i high for 5 cycles, start_i held 1.
  -> next cycle HOLD, core_rst_n_o=0, fetch=0, gating=1; on release -> RESET, full sequence repeats.
- Abort: drop start_i during SETTLE (cycle 3).
  -> IDLE next cycle, fetch_enable_o never rises; re-raise with boot_sel=1 -> boot_addr_o=32'h0000_8000.
- Watchdog (macro on, WDT_CYCLES=100):
  - Hold pio_i constant in RUN -> RESET on the 100th cycle, restart_cnt_o=1.
  - Repeat 300 times -> restart_cnt_o stays 255.
- Heartbeat (macro on, WDT_CYCLES=100): toggle pio_i[0] every 50 cycles for 10,000 cycles -> stays in RUN, restart_cnt_o=0.
- Async reset: assert reset_reset_n=0 mid-RUN between clock edges -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pulpino_boot_ctrl.sv
// rtl/pulpino_boot_ctrl.sv - PULPino boot/run sequencer; optional heartbeat watchdog under PULPINO_BOOT_WDT_EN
module pulpino_boot_ctrl #(
  parameter logic [31:0] BOOT_ADDR0    = 32'h0000_0000,
  parameter logic [31:0] BOOT_ADDR1    = 32'h0000_8000,
  parameter logic [31:0] BOOT_ADDR2    = 32'h1A00_0000,
  parameter logic [31:0] BOOT_ADDR3    = 32'h0008_0000,
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned WDT_CYCLES    = 50_000_000
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        master_reset_i,
  input  logic        start_i,
  input  logic [1:0]  boot_sel_i,
  input  logic [9:0]  pio_i,
  output logic        core_rst_n_o,
  output logic        fetch_enable_o,
  output logic [31:0] boot_addr_o,
  output logic        clock_gating_o,
  output logic        testmode_o,
  output logic [2:0]  state_o,
  output logic [7:0]  restart_cnt_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HOLD   = 3'd1,
    RESET  = 3'd2,
    SETTLE = 3'd3,
    RUN    = 3'd4
  } state_e;

  // Phase counter compares against the last cycle index of each timed state.
  localparam logic [31:0] RST_LAST    = 32'(RST_CYCLES - 1);
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        core_rst_n_q, core_rst_n_d;
  logic        fetch_q, fetch_d;
  logic        gating_q, gating_d;
  logic [31:0] boot_addr_q, boot_addr_d;
  logic [31:0] sel_addr;
  logic        wdt_expire;

`ifdef PULPINO_BOOT_WDT_EN
  localparam logic [31:0] WDT_LAST = 32'(WDT_CYCLES - 1);

  logic [9:0]  pio_q;
  logic [31:0] wdt_q, wdt_d;
  logic [7:0]  rc_q, rc_d;
  logic        heartbeat;

  // Any change on the PIO export since the previous cycle counts as a heartbeat.
  assign heartbeat  = (pio_i != pio_q);
  assign wdt_expire = (state_q == RUN) && (wdt_q == WDT_LAST) && !heartbeat;

  // Watchdog counter only runs while staying in RUN; restart count saturates.
  always_comb begin
    wdt_d = 32'd0;
    if ((state_q == RUN) && (state_d == RUN) && !heartbeat) begin
      wdt_d = wdt_q + 32'd1;
    end
    rc_d = rc_q;
    if (wdt_expire && (state_d == RESET) && (rc_q != 8'hFF)) begin
      rc_d = rc_q + 8'd1;
    end
  end

  // Watchdog registers: heartbeat sample, timeout counter, restart count.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pio_q <= 10'd0;
      wdt_q <= 32'd0;
      rc_q  <= 8'd0;
    end else begin
      pio_q <= pio_i;
      wdt_q <= wdt_d;
      rc_q  <= rc_d;
    end
  end

  assign restart_cnt_o = rc_q;
`else
  logic unused_pio;

  assign unused_pio    = ^pio_i;
  assign wdt_expire    = 1'b0;
  assign restart_cnt_o = 8'd0;
`endif

  // Boot address selected by the switches; only sampled on RESET entry.
  always_comb begin
    sel_addr = BOOT_ADDR0;
    unique case (boot_sel_i)
      2'd0: sel_addr = BOOT_ADDR0;
      2'd1: sel_addr = BOOT_ADDR1;
      2'd2: sel_addr = BOOT_ADDR2;
      2'd3: sel_addr = BOOT_ADDR3;
      default: sel_addr = BOOT_ADDR0;
    endcase
  end

  // State, phase counter and registered outputs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= 32'd0;
      core_rst_n_q <= 1'b0;
      fetch_q      <= 1'b0;
      gating_q     <= 1'b1;
      boot_addr_q  <= BOOT_ADDR0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      core_rst_n_q <= core_rst_n_d;
      fetch_q      <= fetch_d;
      gating_q     <= gating_d;
      boot_addr_q  <= boot_addr_d;
    end
  end

  // Next state: master reset, then abort, then watchdog, then phase completion.
  always_comb begin
    state_d = state_q;
    if (master_reset_i) begin
      state_d = HOLD;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) state_d = RESET;
        end
        HOLD: begin
          state_d = start_i ? RESET : IDLE;
        end
        RESET: begin
          if (!start_i)                state_d = IDLE;
          else if (cnt_q == RST_LAST)  state_d = SETTLE;
        end
        SETTLE: begin
          if (!start_i)                  state_d = IDLE;
          else if (cnt_q == SETTLE_LAST) state_d = RUN;
        end
        RUN: begin
          if (!start_i)        state_d = IDLE;
          else if (wdt_expire) state_d = RESET;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output next values follow the next state so outputs move with state_o.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = 32'd0;
    end else if ((state_q == RESET) || (state_q == SETTLE)) begin
      cnt_d = cnt_q + 32'd1;
    end

    core_rst_n_d = (state_d == SETTLE) || (state_d == RUN);
    fetch_d      = (state_d == RUN);
    gating_d     = (state_d == IDLE) || (state_d == HOLD);

    boot_addr_d = boot_addr_q;
    if ((state_d == RESET) && (state_q != RESET)) begin
      boot_addr_d = sel_addr;
    end
  end

  assign core_rst_n_o   = core_rst_n_q;
  assign fetch_enable_o = fetch_q;
  assign clock_gating_o = gating_q;
  assign boot_addr_o    = boot_addr_q;
  assign testmode_o     = 1'b0;
  assign state_o        = state_q;

endmodule

// File: tb/tb_pulpino_boot_ctrl.sv
// tb/tb_pulpino_boot_ctrl.sv - self-checking bench for pulpino_boot_ctrl
module tb_pulpino_boot_ctrl;

  localparam int RS = 16;
  localparam int ST = 8;
  localparam int WD = 100;
`ifdef PULPINO_BOOT_WDT_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        master;
  logic        start;
  logic [1:0]  sel;
  logic [9:0]  pio;
  logic        core_rst_n;
  logic        fetch;
  logic [31:0] boot_addr;
  logic        gating;
  logic        testmode;
  logic [2:0]  state;
  logic [7:0]  rc;

  int total = 0;
  int fails = 0;

  pulpino_boot_ctrl #(
    .RST_CYCLES   (RS),
    .SETTLE_CYCLES(ST),
    .WDT_CYCLES   (WD)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rstn),
    .master_reset_i(master),
    .start_i       (start),
    .boot_sel_i    (sel),
    .pio_i         (pio),
    .core_rst_n_o  (core_rst_n),
    .fetch_enable_o(fetch),
    .boot_addr_o   (boot_addr),
    .clock_gating_o(gating),
    .testmode_o    (testmode),
    .state_o       (state),
    .restart_cnt_o (rc)
  );

  always #5 clk = ~clk;

  // Reference model: mode (0 idle, 1 hold, 2 booting) plus the edge index at
  // which the current boot began; phase follows from elapsed cycles.
  int          n;
  int          m_mode;
  int          m_t0;
  logic [31:0] m_addr;
  int          m_rc;
  int          m_hb;
  logic [9:0]  m_prev_pio;

  function automatic logic [31:0] addr_of(input logic [1:0] s);
    case (s)
      2'd0: return 32'h0000_0000;
      2'd1: return 32'h0000_8000;
      2'd2: return 32'h1A00_0000;
      default: return 32'h0008_0000;
    endcase
  endfunction

  task automatic model_reset();
    n = 0; m_mode = 0; m_t0 = 0; m_addr = 32'h0; m_rc = 0; m_hb = -100000; m_prev_pio = 10'd0;
  endtask

  task automatic model_step();
    int el_pre, wval, run_start;
    bit hb, expire;
    n++;
    hb = (pio != m_prev_pio);
    m_prev_pio = pio;
    expire = 1'b0;
    if (m_mode == 2 && WDT_ON) begin
      el_pre = (n - 1) - m_t0;
      run_start = m_t0 + RS + ST;
      if (el_pre >= RS + ST) begin
        wval = (n - 1) - ((m_hb > run_start) ? m_hb : run_start);
        expire = (wval == WD - 1) && !hb;
      end
    end
    if (master) m_mode = 1;
    else if (m_mode == 0) begin
      if (start) begin m_mode = 2; m_t0 = n; m_addr = addr_of(sel); end
    end else if (m_mode == 1) begin
      if (start) begin m_mode = 2; m_t0 = n; m_addr = addr_of(sel); end
      else m_mode = 0;
    end else begin
      if (!start) m_mode = 0;
      else if (expire) begin
        m_t0 = n; m_addr = addr_of(sel);
        if (m_rc < 255) m_rc++;
      end
    end
    if (hb) m_hb = n;
  endtask

  task automatic model_out(output logic [2:0] st, output logic rn, output logic f, output logic g);
    int el;
    if (m_mode != 2) begin
      st = (m_mode == 1) ? 3'd1 : 3'd0; rn = 1'b0; f = 1'b0; g = 1'b1;
    end else begin
      el = n - m_t0;
      g = 1'b0;
      if (el < RS)           begin st = 3'd2; rn = 1'b0; f = 1'b0; end
      else if (el < RS + ST) begin st = 3'd3; rn = 1'b1; f = 1'b0; end
      else                   begin st = 3'd4; rn = 1'b1; f = 1'b1; end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, n);
    end
  endtask

  task automatic check_all();
    logic [2:0] st;
    logic rn, f, g;
    model_out(st, rn, f, g);
    chk("m_state", 32'(state), 32'(st));
    chk("m_core_rst_n", 32'(core_rst_n), 32'(rn));
    chk("m_fetch", 32'(fetch), 32'(f));
    chk("m_gating", 32'(gating), 32'(g));
    chk("m_boot_addr", boot_addr, m_addr);
    chk("m_testmode", 32'(testmode), 32'd0);
    chk("m_restart_cnt", 32'(rc), 32'(m_rc));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int lim, input string name);
    int k;
    k = 0;
    while (state !== s && k < lim) begin tick(); k++; end
    chk(name, 32'(state), 32'(s));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  typedef struct {
    logic        start;
    logic        master;
    logic [1:0]  sel;
    int          ncyc;
    logic [2:0]  st;
    logic        rn;
    logic        f;
    logic        g;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int k, rst_k, runc, restarts, guard;
    bit seen;
    logic [2:0] prev_st;

    vecs[0]  = '{1'b0, 1'b0, 2'd2, 1,  3'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0000};
    vecs[1]  = '{1'b1, 1'b0, 2'd2, 1,  3'd2, 1'b0, 1'b0, 1'b0, 32'h1A00_0000};
    vecs[2]  = '{1'b1, 1'b0, 2'd0, 15, 3'd2, 1'b0, 1'b0, 1'b0, 32'h1A00_0000};
    vecs[3]  = '{1'b1, 1'b0, 2'd0, 1,  3'd3, 1'b1, 1'b0, 1'b0, 32'h1A00_0000};
    vecs[4]  = '{1'b1, 1'b0, 2'd1, 7,  3'd3, 1'b1, 1'b0, 1'b0, 32'h1A00_0000};
    vecs[5]  = '{1'b1, 1'b0, 2'd1, 1,  3'd4, 1'b1, 1'b1, 1'b0, 32'h1A00_0000};
    vecs[6]  = '{1'b1, 1'b1, 2'd1, 1,  3'd1, 1'b0, 1'b0, 1'b1, 32'h1A00_0000};
    vecs[7]  = '{1'b1, 1'b1, 2'd1, 4,  3'd1, 1'b0, 1'b0, 1'b1, 32'h1A00_0000};
    vecs[8]  = '{1'b1, 1'b0, 2'd3, 1,  3'd2, 1'b0, 1'b0, 1'b0, 32'h0008_0000};
    vecs[9]  = '{1'b1, 1'b0, 2'd0, 18, 3'd3, 1'b1, 1'b0, 1'b0, 32'h0008_0000};
    vecs[10] = '{1'b0, 1'b0, 2'd0, 1,  3'd0, 1'b0, 1'b0, 1'b1, 32'h0008_0000};
    vecs[11] = '{1'b1, 1'b0, 2'd1, 1,  3'd2, 1'b0, 1'b0, 1'b0, 32'h0000_8000};
    vecs[12] = '{1'b0, 1'b0, 2'd1, 2,  3'd0, 1'b0, 1'b0, 1'b1, 32'h0000_8000};

    rstn = 1'b0; master = 1'b0; start = 1'b0; sel = 2'd0; pio = 10'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("rst_fetch", 32'(fetch), 32'd0);
    chk("rst_gating", 32'(gating), 32'd1);
    chk("rst_boot_addr", boot_addr, 32'h0);
    chk("rst_restart_cnt", 32'(rc), 32'd0);
    chk("rst_testmode", 32'(testmode), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Table: boot sequence, master reset mid-RUN, abort and reboot.
    for (int i = 0; i < 13; i++) begin
      start = vecs[i].start; master = vecs[i].master; sel = vecs[i].sel;
      repeat (vecs[i].ncyc) tick();
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
      chk($sformatf("vec%0d_core_rst_n", i), 32'(core_rst_n), 32'(vecs[i].rn));
      chk($sformatf("vec%0d_fetch", i), 32'(fetch), 32'(vecs[i].f));
      chk($sformatf("vec%0d_gating", i), 32'(gating), 32'(vecs[i].g));
      chk($sformatf("vec%0d_boot_addr", i), boot_addr, vecs[i].addr);
    end

    // Boot latency: core reset release and fetch enable counted from RESET.
    sel = 2'd2; start = 1'b1;
    tick();
    chk("lat_reset_entry", 32'(state), 32'd2);
    k = 0;
    while (core_rst_n !== 1'b1 && k < 100) begin tick(); k++; end
    rst_k = k;
    chk("lat_core_rst_rise", 32'(rst_k), 32'(RS));
    while (fetch !== 1'b1 && k < 100) begin tick(); k++; end
    chk("lat_fetch_rise", 32'(k), 32'(RS + ST));
    chk("lat_state_run", 32'(state), 32'd4);
    chk("lat_boot_addr", boot_addr, 32'h1A00_0000);

    // Abort in the third SETTLE cycle, fetch must stay low.
    start = 1'b0; tick();
    start = 1'b1; sel = 2'd0; tick();
    wait_state(3'd3, 40, "abort_reach_settle");
    tick(); tick();
    chk("abort_settle_cycle3", 32'(state), 32'd3);
    start = 1'b0; tick();
    chk("abort_idle", 32'(state), 32'd0);
    seen = 1'b0;
    repeat (40) begin tick(); if (fetch) seen = 1'b1; end
    chk("abort_no_fetch", 32'(seen), 32'd0);
    sel = 2'd1; start = 1'b1; tick();
    chk("abort_reboot_addr", boot_addr, 32'h0000_8000);

    // Asynchronous reset between clock edges in RUN.
    repeat (RS + ST + 2) tick();
    chk("arst_pre_run", 32'(state), 32'd4);
    #3;
    rstn = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("arst_fetch", 32'(fetch), 32'd0);
    chk("arst_gating", 32'(gating), 32'd1);
    chk("arst_boot_addr", boot_addr, 32'h0);
    chk("arst_restart_cnt", 32'(rc), 32'd0);
    model_reset();
    start = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      start  = ($urandom_range(0, 99) < 98);
      master = ($urandom_range(0, 199) == 0);
      sel    = 2'($urandom);
      if ($urandom_range(0, 149) == 0) pio = 10'($urandom);
      tick();
      check_all();
    end

`ifdef PULPINO_BOOT_WDT_EN
    // Watchdog: constant heartbeat restarts the core every 100 RUN cycles.
    master = 1'b0; start = 1'b0; sel = 2'd0; pio = 10'h155;
    do_reset();
    start = 1'b1;
    wait_state(3'd4, 100, "wdt_reach_run");
    runc = 1;
    k = 0;
    while (state === 3'd4 && k < 1000) begin
      tick(); check_all(); k++;
      if (state === 3'd4) runc++;
    end
    chk("wdt_run_len", 32'(runc), 32'(WD));
    chk("wdt_state_reset", 32'(state), 32'd2);
    chk("wdt_restart_cnt1", 32'(rc), 32'd1);
    restarts = 1;
    guard = 0;
    prev_st = state;
    while (restarts < 300 && guard < 300 * 130) begin
      tick(); check_all(); guard++;
      if (prev_st === 3'd4 && state === 3'd2) restarts++;
      prev_st = state;
    end
    chk("wdt_restarts", 32'(restarts), 32'd300);
    chk("wdt_restart_sat", 32'(rc), 32'd255);

    // Heartbeat: toggling pio[0] every 50 cycles keeps the core running.
    start = 1'b0;
    do_reset();
    start = 1'b1;
    wait_state(3'd4, 100, "hb_reach_run");
    for (int i = 0; i < 10000; i++) begin
      if (i % 50 == 0) pio[0] = ~pio[0];
      tick(); check_all();
    end
    chk("hb_state_run", 32'(state), 32'd4);
    chk("hb_restart_cnt", 32'(rc), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", total, fails);
    $finish;
  end

endmodule
